// File: rtl/step_pkg.sv
// Shared definitions for the STEP/DIR pulse generator and its motion controller.
//   PERIOD_W   : width of the period word and of the internal period/phase counters
//   STEP_CNT_W : width of the step counter (the controller reads the same width back)
//   step_state_e : pulse generator states
package step_pkg;

    localparam int unsigned PERIOD_W   = 21;
    localparam int unsigned STEP_CNT_W = 24;

    typedef enum logic [1:0] {
        StIdle,
        StDirWait,
        StHigh,
        StLow
    } step_state_e;

endpackage

// File: rtl/step_ramp.sv
// Combinational next-period calculator for the per-step speed ramp.
// Moves cur toward tgt by at most RAMP_STEP, never overshooting tgt.
//   cur_i  : period currently in use
//   tgt_i  : clamped target period
//   next_o : period to use for the next step
module step_ramp
    import step_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 10000
) (
    input  logic [PERIOD_W-1:0] cur_i,
    input  logic [PERIOD_W-1:0] tgt_i,
    output logic [PERIOD_W-1:0] next_o
);

    localparam logic [PERIOD_W:0] Step = (PERIOD_W + 1)'(RAMP_STEP);

    logic [PERIOD_W:0] cur_x;
    logic [PERIOD_W:0] tgt_x;
    logic [PERIOD_W:0] down_gap;
    logic [PERIOD_W:0] up_sum;

    // One extra bit so cur - tgt and cur + Step can neither wrap nor overflow.
    always_comb begin
        cur_x    = {1'b0, cur_i};
        tgt_x    = {1'b0, tgt_i};
        down_gap = cur_x - tgt_x;
        up_sum   = cur_x + Step;
        next_o   = cur_i;
        if (tgt_x < cur_x) begin
            if (down_gap > Step) begin
                next_o = cur_i - Step[PERIOD_W-1:0];
            end else begin
                next_o = tgt_i;
            end
        end else if (tgt_x > cur_x) begin
            if (up_sum < tgt_x) begin
                next_o = up_sum[PERIOD_W-1:0];
            end else begin
                next_o = tgt_i;
            end
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// STEP/DIR pulse train generator for one stepper axis, with per-step speed ramp,
// direction-setup gap and glitch-free stop (a started step pulse always completes).
//   clk_50m   : system clock
//   rst       : asynchronous active-low reset
//   en_n      : 0 = run, 1 = stop
//   dirc      : requested direction
//   period_in : target step period in clk cycles
//   step_out  : registered step pulse to the driver
//   dir_out   : registered direction to the driver
//   running   : high in any state other than idle
//   step_cnt  : count of step_out rising edges, wrapping
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int unsigned PULSE_HIGH   = 1000,
    parameter int unsigned DIR_SETUP    = 500,
    parameter int unsigned START_PERIOD = 250000,
    parameter int unsigned RAMP_STEP    = 10000
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    input  logic                  en_n,
    input  logic                  dirc,
    input  logic [PERIOD_W-1:0]   period_in,
    output logic                  step_out,
    output logic                  dir_out,
    output logic                  running,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    localparam logic [PERIOD_W:0]   PulseHighX  = (PERIOD_W + 1)'(PULSE_HIGH);
    localparam logic [PERIOD_W:0]   MinPeriodX  = (PERIOD_W + 1)'(2 * PULSE_HIGH);
    localparam logic [PERIOD_W:0]   OneX        = (PERIOD_W + 1)'(1);
    localparam logic [PERIOD_W-1:0] HighLast    = PERIOD_W'(PULSE_HIGH - 1);
    localparam logic [PERIOD_W-1:0] DirLast     = PERIOD_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] StartPeriod = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] PhaseOne    = PERIOD_W'(1);
    localparam logic [STEP_CNT_W-1:0] CntOne    = STEP_CNT_W'(1);

    step_state_e           state_q;
    logic [PERIOD_W-1:0]   phase_q;
    logic [PERIOD_W-1:0]   cur_q;
    logic                  step_q;
    logic                  dir_q;
    logic                  run_q;
    logic [STEP_CNT_W-1:0] cnt_q;

    logic [PERIOD_W-1:0]   tgt;
    logic [PERIOD_W-1:0]   cur_ramped;
    logic [PERIOD_W:0]     low_last;
    logic                  low_done;

    // Never ramp toward a period shorter than two high times.
    always_comb begin
        tgt = period_in;
        if ({1'b0, period_in} < MinPeriodX) begin
            tgt = MinPeriodX[PERIOD_W-1:0];
        end
    end

    // LOW lasts cur - PULSE_HIGH cycles so rising edges are exactly cur apart.
    always_comb begin
        low_last = {1'b0, cur_q} - PulseHighX - OneX;
        low_done = ({1'b0, phase_q} == low_last);
    end

    step_ramp #(
        .RAMP_STEP(RAMP_STEP)
    ) u_ramp (
        .cur_i (cur_q),
        .tgt_i (tgt),
        .next_o(cur_ramped)
    );

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            cur_q   <= StartPeriod;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!en_n) begin
                        state_q <= StDirWait;
                        phase_q <= '0;
                        dir_q   <= dirc;
                        cur_q   <= StartPeriod;
                        run_q   <= 1'b1;
                    end
                end
                StDirWait: begin
                    if (en_n) begin
                        state_q <= StIdle;
                        run_q   <= 1'b0;
                    end else if (phase_q == DirLast) begin
                        // First step after a direction gap runs at START_PERIOD unramped.
                        state_q <= StHigh;
                        phase_q <= '0;
                        step_q  <= 1'b1;
                        cnt_q   <= cnt_q + CntOne;
                    end else begin
                        phase_q <= phase_q + PhaseOne;
                    end
                end
                StHigh: begin
                    // en_n is ignored until the pulse is complete.
                    if (phase_q == HighLast) begin
                        step_q  <= 1'b0;
                        phase_q <= '0;
                        if (en_n) begin
                            state_q <= StIdle;
                            run_q   <= 1'b0;
                        end else begin
                            state_q <= StLow;
                        end
                    end else begin
                        phase_q <= phase_q + PhaseOne;
                    end
                end
                StLow: begin
                    if (en_n) begin
                        state_q <= StIdle;
                        run_q   <= 1'b0;
                    end else if (low_done) begin
                        phase_q <= '0;
                        if (dirc != dir_q) begin
                            state_q <= StDirWait;
                            dir_q   <= dirc;
                            cur_q   <= StartPeriod;
                        end else begin
                            state_q <= StHigh;
                            cur_q   <= cur_ramped;
                            step_q  <= 1'b1;
                            cnt_q   <= cnt_q + CntOne;
                        end
                    end else begin
                        phase_q <= phase_q + PhaseOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    step_q  <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign step_out = step_q;
    assign dir_out  = dir_q;
    assign running  = run_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: timestamp-based behavioural model checked every cycle,
// directed scenarios with literal edge spacings, then randomized stimulus.
module tb_step_pulse_gen;
    import step_pkg::*;

    localparam int PH = 4;
    localparam int DS = 3;
    localparam int SP = 40;
    localparam int RS = 8;

    logic                  clk_50m = 1'b0;
    logic                  rst = 1'b0;
    logic                  en_n = 1'b1;
    logic                  dirc = 1'b1;
    logic [PERIOD_W-1:0]   period_in = PERIOD_W'(40);
    logic                  step_out;
    logic                  dir_out;
    logic                  running;
    logic [STEP_CNT_W-1:0] step_cnt;

    step_pulse_gen #(
        .PULSE_HIGH  (PH),
        .DIR_SETUP   (DS),
        .START_PERIOD(SP),
        .RAMP_STEP   (RS)
    ) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .en_n     (en_n),
        .dirc     (dirc),
        .period_in(period_in),
        .step_out (step_out),
        .dir_out  (dir_out),
        .running  (running),
        .step_cnt (step_cnt)
    );

    always #5 clk_50m = ~clk_50m;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int nrise    = 0;
    int rise_q[$];
    logic prev_step = 1'b0;

    int ramp_dn [5] = '{40, 32, 24, 16, 16};
    int ramp_up [4] = '{16, 24, 32, 40};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model: tracks time since the last rising edge (or the remaining setup gap)
    // and the period in force; outputs follow from those numbers.
    bit          m_on  = 1'b0;
    bit          m_dir = 1'b0;
    int          m_gap = 0;
    int          m_age = 0;
    int          m_cur = SP;
    logic [23:0] m_cnt = '0;

    task automatic model_reset();
        m_on  = 1'b0;
        m_dir = 1'b0;
        m_gap = 0;
        m_age = 0;
        m_cur = SP;
        m_cnt = '0;
    endtask

    task automatic model_step(input bit en, input bit d, input int p);
        int nxt;
        int tgt;
        if (!m_on) begin
            if (!en) begin
                m_on  = 1'b1;
                m_dir = d;
                m_cur = SP;
                m_gap = DS;
            end
            return;
        end
        if (m_gap > 0) begin
            if (en) begin
                m_on = 1'b0;
                return;
            end
            m_gap--;
            if (m_gap == 0) begin
                m_age = 0;
                m_cnt++;
            end
            return;
        end
        nxt = m_age + 1;
        if (nxt < PH) begin
            m_age = nxt;
            return;
        end
        if (en) begin
            m_on = 1'b0;
            return;
        end
        if (nxt < m_cur) begin
            m_age = nxt;
            return;
        end
        if (d != m_dir) begin
            m_dir = d;
            m_cur = SP;
            m_gap = DS;
            return;
        end
        tgt = (p > 2 * PH) ? p : 2 * PH;
        if (tgt < m_cur) m_cur = (m_cur - RS > tgt) ? m_cur - RS : tgt;
        else if (tgt > m_cur) m_cur = (m_cur + RS < tgt) ? m_cur + RS : tgt;
        m_age = 0;
        m_cnt++;
    endtask

    initial forever begin
        @(posedge clk_50m);
        cyc++;
    end

    // Model update and per-cycle compare; also records DUT rising-edge times.
    initial forever begin
        bit exp_step;
        @(posedge clk_50m or negedge rst);
        if (!rst) model_reset();
        else model_step(en_n, dirc, int'(period_in));
        #1;
        exp_step = m_on && (m_gap == 0) && (m_age < PH);
        chk("step_out", 32'(step_out), 32'(exp_step));
        chk("dir_out", 32'(dir_out), 32'(m_dir));
        chk("running", 32'(running), 32'(m_on));
        chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
        if (step_out === 1'b1 && prev_step === 1'b0) begin
            rise_q.push_back(cyc);
            nrise++;
        end
        prev_step = step_out;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            #2;
        end
    endtask

    task automatic wait_rise(input int bound);
        int n0;
        int k;
        n0 = nrise;
        k  = 0;
        while (nrise == n0 && k < bound) begin
            @(posedge clk_50m);
            #2;
            k++;
        end
        chk("rise_within_bound", 32'(nrise != n0), 32'd1);
    endtask

    function automatic int gap(input int i);
        if (i < 1 || i >= rise_q.size()) return -1;
        return rise_q[i] - rise_q[i-1];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("rst_step", 32'(step_out), 32'd0);
        chk("rst_dir", 32'(dir_out), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cnt", 32'(step_cnt), 32'd0);

        // Start
        en_n = 1'b0;
        tick(1);
        chk("start_dir", 32'(dir_out), 32'd1);
        chk("start_running", 32'(running), 32'd1);
        chk("start_gap_step", 32'(step_out), 32'd0);
        tick(2);
        chk("start_gap_end", 32'(step_out), 32'd0);
        tick(1);
        chk("start_rise", 32'(step_out), 32'd1);
        chk("start_cnt1", 32'(step_cnt), 32'd1);
        b = rise_q.size() - 1;
        tick(3);
        chk("start_high4", 32'(step_out), 32'd1);
        tick(1);
        chk("start_fall", 32'(step_out), 32'd0);
        wait_rise(100);
        wait_rise(100);
        chk("start_gap1", 32'(gap(b + 1)), 32'd40);
        chk("start_gap2", 32'(gap(b + 2)), 32'd40);
        chk("start_cnt3", 32'(step_cnt), 32'd3);

        // Ramp down then back up
        period_in = PERIOD_W'(16);
        b = rise_q.size() - 1;
        repeat (5) wait_rise(100);
        for (int i = 0; i < 5; i++) chk("ramp_down_gap", 32'(gap(b + 1 + i)), 32'(ramp_dn[i]));
        period_in = PERIOD_W'(40);
        b = rise_q.size() - 1;
        repeat (4) wait_rise(100);
        for (int i = 0; i < 4; i++) chk("ramp_up_gap", 32'(gap(b + 1 + i)), 32'(ramp_up[i]));

        // Stop during the second HIGH cycle
        tick(1);
        en_n = 1'b1;
        tick(1);
        chk("stop_high3", 32'(step_out), 32'd1);
        tick(1);
        chk("stop_high4", 32'(step_out), 32'd1);
        tick(1);
        chk("stop_fall", 32'(step_out), 32'd0);
        chk("stop_running", 32'(running), 32'd0);
        tick(5);
        chk("stop_idle", 32'(running), 32'd0);
        chk("stop_cnt", 32'(step_cnt), 32'd12);
        en_n = 1'b0;
        b = rise_q.size() - 1;
        wait_rise(100);
        wait_rise(100);
        chk("restart_gap", 32'(gap(b + 2)), 32'd40);

        // Reverse mid-LOW
        tick(10);
        dirc = 1'b0;
        b = rise_q.size() - 1;
        wait_rise(150);
        chk("reverse_gap", 32'(gap(b + 1)), 32'd43);
        chk("reverse_dir", 32'(dir_out), 32'd0);
        wait_rise(100);
        chk("reverse_first", 32'(gap(b + 2)), 32'd40);

        // Clamp
        period_in = PERIOD_W'(3);
        b = rise_q.size() - 1;
        repeat (6) wait_rise(100);
        chk("clamp_gap5", 32'(gap(b + 5)), 32'd8);
        chk("clamp_gap6", 32'(gap(b + 6)), 32'd8);

        // Reset during HIGH
        dirc = 1'b1;
        wait_rise(100);
        chk("pre_reset_dir", 32'(dir_out), 32'd1);
        tick(1);
        #1 rst = 1'b0;
        #1;
        chk("areset_step", 32'(step_out), 32'd0);
        chk("areset_cnt", 32'(step_cnt), 32'd0);
        chk("areset_dir", 32'(dir_out), 32'd0);
        en_n = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(4);
        chk("post_reset_idle", 32'(running), 32'd0);
        chk("post_reset_step", 32'(step_out), 32'd0);
        en_n = 1'b0;
        tick(1);
        chk("post_reset_run", 32'(running), 32'd1);
        chk("post_reset_dir", 32'(dir_out), 32'd1);

        // Randomized stimulus, model checks every cycle
        period_in = PERIOD_W'(20);
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (en_n) begin
                if ($urandom_range(0, 99) < 5) en_n = 1'b0;
            end else begin
                if ($urandom_range(0, 99) == 0) en_n = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) dirc = ~dirc;
            if ($urandom_range(0, 99) == 0) period_in = PERIOD_W'($urandom_range(0, 70));
            if (i == 1500) begin
                #1 rst = 1'b0;
                #3 rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
